// File: rtl/teatimer_pkg.sv
// rtl/teatimer_pkg.sv - shared states, channel offsets and colour lookup for teatimer_fb
package teatimer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [1:0] CH_G = 2'd0;
  localparam logic [1:0] CH_R = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  typedef enum logic [1:0] {
    COL_OFF  = 2'd0,
    COL_IDLE = 2'd1,
    COL_RUN  = 2'd2,
    COL_DONE = 2'd3
  } colour_e;

  // Idle is a dim blue, running a full green, done a full red.
  function automatic logic [7:0] colour_byte(colour_e col, logic [1:0] ch, logic [7:0] bright);
    logic [7:0] b;
    b = 8'h00;
    case (col)
      COL_IDLE: if (ch == CH_B) b = bright >> 2;
      COL_RUN:  if (ch == CH_G) b = bright;
      COL_DONE: if (ch == CH_R) b = bright;
      default:  b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/teatimer_fb_debounce.sv
// rtl/teatimer_fb_debounce.sv - button synchroniser and debouncer, one pulse per accepted press
module teatimer_fb_debounce
  import teatimer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // level_q is the accepted (debounced) level; it flips only after a full stable run.
  always_comb begin
    sync_d  = {sync_q[0], btn_n};
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/teatimer_fb.sv
// rtl/teatimer_fb.sv - tea timer FSM that repaints the LED framebuffer on every visible change
module teatimer_fb
  import teatimer_pkg::*;
#(
  parameter int         CLK_HZ          = 20000000,
  parameter int         BREW_SECS       = 180,
  parameter int         NUM_LEDS        = 60,
  parameter int         DEBOUNCE_CYCLES = 200000,
  parameter logic [7:0] BRIGHT          = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_start_n,
  input  logic       sw_stop_n,
  output logic [8:0] w_addr,
  output logic [7:0] din,
  output logic       write_en,
  output logic [1:0] state_o
);

  localparam int             TW        = $clog2(CLK_HZ + 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(CLK_HZ - 1);
  localparam logic [9:0]     BREW      = 10'(BREW_SECS);
  localparam logic [8:0]     ADDR_LAST = 9'(3 * NUM_LEDS - 1);

  logic start_p, stop_p;

  teatimer_fb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbs_start (
    .clk(clk), .rst(rst), .btn_n(sw_start_n), .press_o(start_p)
  );

  teatimer_fb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbs_stop (
    .clk(clk), .rst(rst), .btn_n(sw_stop_n), .press_o(stop_p)
  );

  state_e        state_q, state_d;
  logic [9:0]    rem_q, rem_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          flash_q, flash_d;
  logic          pend_q, pend_d;
  logic          sweep_q, sweep_d;
  logic [8:0]    addr_q, addr_d;
  logic [7:0]    led_q, led_d;
  logic [1:0]    ch_q, ch_d;
  state_e        snap_state_q, snap_state_d;
  logic [9:0]    snap_rem_q, snap_rem_d;
  logic          snap_flash_q, snap_flash_d;

  logic          tick;
  logic          render_req;
  colour_e       col;
  logic [31:0]   lit_lhs, lit_rhs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      tick_cnt_q   <= '0;
      flash_q      <= 1'b0;
      pend_q       <= 1'b1;
      sweep_q      <= 1'b0;
      addr_q       <= '0;
      led_q        <= '0;
      ch_q         <= CH_G;
      snap_state_q <= ST_IDLE;
      snap_rem_q   <= '0;
      snap_flash_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      tick_cnt_q   <= tick_cnt_d;
      flash_q      <= flash_d;
      pend_q       <= pend_d;
      sweep_q      <= sweep_d;
      addr_q       <= addr_d;
      led_q        <= led_d;
      ch_q         <= ch_d;
      snap_state_q <= snap_state_d;
      snap_rem_q   <= snap_rem_d;
      snap_flash_q <= snap_flash_d;
    end
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  // Stop wins over everything; start only (re)arms from IDLE or DONE.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    flash_d    = flash_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    if (stop_p && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      flash_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_p) begin
            state_d    = ST_RUNNING;
            rem_d      = BREW;
            tick_cnt_d = '0;
          end
        end
        ST_RUNNING: begin
          if (tick) begin
            rem_d = rem_q - 10'd1;
            if (rem_q == 10'd1) begin
              state_d = ST_DONE;
              flash_d = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (start_p) begin
            state_d    = ST_RUNNING;
            rem_d      = BREW;
            flash_d    = 1'b0;
            tick_cnt_d = '0;
          end else if (tick) begin
            flash_d = ~flash_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign render_req = (state_d != state_q) || (rem_d != rem_q) || (flash_d != flash_q);

  // A request landing on the sweep-start cycle stays pending: the snapshot holds the old image.
  always_comb begin
    sweep_d      = sweep_q;
    addr_d       = addr_q;
    led_d        = led_q;
    ch_d         = ch_q;
    snap_state_d = snap_state_q;
    snap_rem_d   = snap_rem_q;
    snap_flash_d = snap_flash_q;
    pend_d       = pend_q | render_req;
    if (sweep_q) begin
      if (addr_q == ADDR_LAST) begin
        sweep_d = 1'b0;
        addr_d  = '0;
        led_d   = '0;
        ch_d    = CH_G;
      end else begin
        addr_d = addr_q + 9'd1;
        if (ch_q == CH_B) begin
          ch_d  = CH_G;
          led_d = led_q + 8'd1;
        end else begin
          ch_d = ch_q + 2'd1;
        end
      end
    end else if (pend_q) begin
      sweep_d      = 1'b1;
      pend_d       = render_req;
      snap_state_d = state_q;
      snap_rem_d   = rem_q;
      snap_flash_d = flash_q;
    end
  end

  assign lit_lhs = 32'(led_q) * 32'(BREW_SECS);
  assign lit_rhs = 32'(snap_rem_q) * 32'(NUM_LEDS);

  always_comb begin
    col = COL_OFF;
    case (snap_state_q)
      ST_IDLE:    col = COL_IDLE;
      ST_RUNNING: if (lit_lhs < lit_rhs) col = COL_RUN;
      ST_DONE:    if (snap_flash_q) col = COL_DONE;
      default:    col = COL_OFF;
    endcase
  end

  assign din      = sweep_q ? colour_byte(col, ch_q, BRIGHT) : 8'h00;
  assign write_en = sweep_q;
  assign w_addr   = addr_q;
  assign state_o  = state_q;

endmodule

// File: doc/teatimer_fb.md
Name: teatimer_fb

Overview:
Tea-timer controller that sits directly upstream of the framebuf RAM write port and renders the countdown state into it; the neopixel driver scans that RAM out to the LED strip. It runs on the single 20 MHz system clock and derives its 1 Hz tick internally from a clock-enable rather than a divided clock. Debounced start/stop buttons drive an IDLE/RUNNING/DONE state machine. After every state change or second tick, the block rewrites the full pixel image (GRB, 3 bytes per LED).

Parameters:
CLK_HZ, 20000000, system clock frequency; tick every CLK_HZ cycles
BREW_SECS, 180, countdown length in seconds (1..1023)
NUM_LEDS, 60, pixels in strip; 3*NUM_LEDS must be <= 512
DEBOUNCE_CYCLES, 200000, stable-level cycles required to accept a button edge
BRIGHT, 8'h20, colour channel intensity for lit pixels

Ports:
clk  in  1  system clock (20 MHz PLL output)
rst  in  1  reset; asynchronous and active-high
sw_start_n  in  1  start button, active-low, asynchronous to clk
sw_stop_n  in  1  stop button, active-low, asynchronous to clk
w_addr  out  9  framebuf write byte address
din  out  8  framebuf write data
write_en  out  1  framebuf write strobe, one byte per cycle
state_o  out  2  current state (0 IDLE, 1 RUNNING, 2 DONE) for debug

Behaviour:
- Reset: state IDLE, remaining=0, tick counter 0, flash=0, write_en=0, w_addr=0, din=0. A render request is pending, so the first sweep after reset paints the IDLE image.
- Button input path: 2-flop synchroniser, then debounce. A press is accepted when the synchronised level has been low for DEBOUNCE_CYCLES consecutive cycles. Each accepted press yields exactly one 1-cycle pulse. Release needs the same stability before the next press can be accepted. Holding a button does not repeat the pulse.
- Tick: the counter counts 0..CLK_HZ-1 and pulses at wrap. The counter is cleared on entry to RUNNING, so the first decrement occurs exactly CLK_HZ cycles after the start pulse.
- State transitions (stop has priority when both pulses occur in the same cycle):
  - IDLE + start -> RUNNING, remaining=BREW_SECS.
  - RUNNING + tick -> remaining-1. If remaining was 1 -> DONE, flash=1.
  - RUNNING + start: ignored (no restart).
  - RUNNING/DONE + stop -> IDLE.
  - DONE + tick -> flash toggles.
  - DONE + start -> RUNNING (fresh brew).
  - IDLE + stop: no effect.
- Render request: raised by any state change, any remaining decrement, or any flash toggle.
- Pixel image, with LED i at bytes 3i (G), 3i+1 (R), 3i+2 (B):
  - IDLE: every LED G=0, R=0, B=BRIGHT>>2.
  - RUNNING: LED i is lit (G=BRIGHT, R=0, B=0) iff i*BREW_SECS < remaining*NUM_LEDS, otherwise all zero. Compare at ≥21-bit width.
  - DONE: every LED R=BRIGHT, G=B=0 when flash=1; all zero when flash=0.
- Sweep: starts the cycle after a request is seen while idle. It asserts write_en for exactly 3*NUM_LEDS consecutive cycles with w_addr 0,1,2,... and din valid in the same cycle. Image inputs are snapshotted at sweep start, so one sweep is internally consistent.
- A request arriving mid-sweep sets pending. A new sweep begins the cycle after the current one ends. Multiple requests collapse into one.
- write_en is deasserted between sweeps. Addresses >= 3*NUM_LEDS are never written.
- Reset mid-sweep: write_en drops immediately (asynchronously). After release, the IDLE repaint starts from address 0.

Decomposition:
- Shared package/include teatimer_pkg:
  - state encodings ST_IDLE/ST_RUNNING/ST_DONE.
  - byte-offset constants CH_G=0, CH_R=1, CH_B=2.
  - colour constants for idle/run/done.
- One natural sub-module: debounce, parameterised by DEBOUNCE_CYCLES, containing the synchroniser and the press-pulse output. It is instantiated twice.
- Renderer and FSM stay in teatimer_fb.

Test Plan:
All scenarios use CLK_HZ=10, BREW_SECS=4, NUM_LEDS=4, DEBOUNCE_CYCLES=3, BRIGHT=8'h20.
1. Release reset -> one sweep of 12 writes, addr 0..11. Every B byte =8'h08; G and R bytes =0. write_en low afterwards.
2. Start held low 3 cycles -> single pulse, RUNNING, sweep with addrs 0,3,6,9 =8'h20. Bouncy 2-cycle low glitch before that -> no pulse, no sweep.
3. RUNNING, 10 cycles after start -> remaining=3, sweep lights LEDs 0..2 and LED 3 is all zero. After 40 cycles -> DONE, all R bytes =8'h20. 10 cycles later -> all bytes 0 (flash off).
4. Stop pulse during RUNNING mid-sweep -> current sweep completes all 12 writes, then exactly one IDLE sweep follows.
5. Start and stop accepted in the same cycle from DONE -> IDLE, not RUNNING.
6. Assert rst during sweep at addr 5 -> write_en=0 the same cycle. After release, a full IDLE sweep from addr 0.
